// File: rtl/timer_counter_pkg.sv
// Shared definitions for timer_counter: register offsets, CTRL fields, MODE and FSM encodings.
// Optional prescaler support is selected in the top by TC_PRESCALER_EN.
package timer_counter_pkg;

  localparam logic [1:0] ADDR_CTRL     = 2'd0;
  localparam logic [1:0] ADDR_PRESET   = 2'd1;
  localparam logic [1:0] ADDR_COUNT    = 2'd2;
  localparam logic [1:0] ADDR_PRESCALE = 2'd3;

  localparam logic [1:0] MODE_ONESHOT = 2'b00;
  localparam logic [1:0] MODE_RELOAD  = 2'b01;

  localparam logic [31:0] TC_BASE_ADDR = 32'h0000_7F00;

  // CTRL register layout, MSB first: IM, MODE[1:0], EN
  typedef struct packed {
    logic       im;
    logic [1:0] mode;
    logic       en;
  } ctrl_t;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_CNT  = 2'd2,
    ST_INT  = 2'd3
  } tc_state_e;

  // MODE=1x falls back to one-shot
  function automatic logic is_reload(input logic [1:0] mode);
    return mode == MODE_RELOAD;
  endfunction

endpackage

// File: rtl/tc_prescaler.sv
// Tick divider: tick when the free counter equals div, then wraps; clr holds it at 0.
// Latency: tick is combinational from the counter; no backpressure.
module tc_prescaler #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         clr,
  input  logic [W-1:0] div,
  output logic         tick
);

  logic [W-1:0] cnt_q, cnt_d;

  assign tick = (cnt_q == div);

  always_comb begin
    cnt_d = cnt_q + {{(W-1){1'b0}}, 1'b1};
    if (clr || tick) cnt_d = '0;
  end

  always_ff @(posedge clk) begin
    if (reset) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

endmodule

// File: rtl/timer_counter.sv
// Memory-mapped down-counting timer with IRQ; TC_PRESCALER_EN adds the PRESCALE register.
// Reads are combinational (latency 0), writes take effect at the next edge; no backpressure.
module timer_counter
  import timer_counter_pkg::*;
#(
  parameter int COUNT_W    = 32,
  parameter int PRESCALE_W = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [3:2]  Addr,
  input  logic        WE,
  input  logic [31:0] Din,
  output logic [31:0] Dout,
  output logic        IRQ
);

  localparam logic [COUNT_W-1:0] ONE = {{(COUNT_W-1){1'b0}}, 1'b1};

  ctrl_t                 ctrl_q, ctrl_d;
  logic [COUNT_W-1:0]    preset_q, preset_d;
  logic [COUNT_W-1:0]    count_q, count_d;
  logic                  irq_flag_q, irq_flag_d;
  tc_state_e             state_q, state_d;
  logic                  tick;
  logic [PRESCALE_W-1:0] prescale_val;

`ifdef TC_PRESCALER_EN
  logic [PRESCALE_W-1:0] prescale_q, prescale_d;

  assign prescale_val = prescale_q;

  tc_prescaler #(.W(PRESCALE_W)) u_prescaler (
    .clk   (clk),
    .reset (reset),
    .clr   ((state_q == ST_IDLE) || (state_q == ST_LOAD)),
    .div   (prescale_q),
    .tick  (tick)
  );

  always_comb begin
    prescale_d = prescale_q;
    if (WE && (Addr == ADDR_PRESCALE)) prescale_d = Din[PRESCALE_W-1:0];
  end

  always_ff @(posedge clk) begin
    if (reset) prescale_q <= '0;
    else       prescale_q <= prescale_d;
  end
`else
  assign tick         = 1'b1;
  assign prescale_val = '0;
`endif

  always_comb begin
    ctrl_d     = ctrl_q;
    preset_d   = preset_q;
    count_d    = count_q;
    irq_flag_d = irq_flag_q;
    state_d    = state_q;

    case (state_q)
      ST_IDLE: if (ctrl_q.en) state_d = ST_LOAD;
      ST_LOAD: begin
        count_d = preset_q;
        state_d = ST_CNT;
      end
      ST_CNT: begin
        if (!ctrl_q.en) begin
          state_d = ST_IDLE;
        end else if (tick) begin
          if (count_q > ONE) begin
            count_d = count_q - ONE;
          end else begin
            count_d    = '0;
            irq_flag_d = 1'b1;
            state_d    = ST_INT;
          end
        end
      end
      ST_INT: begin
        if (is_reload(ctrl_q.mode)) begin
          irq_flag_d = 1'b0;
          state_d    = ST_LOAD;
        end else begin
          ctrl_d.en = 1'b0;
          state_d   = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // CPU writes are applied last so they override FSM updates of the same field
    if (WE) begin
      case (Addr)
        ADDR_CTRL: begin
          ctrl_d     = ctrl_t'(Din[3:0]);
          irq_flag_d = 1'b0;
        end
        ADDR_PRESET: preset_d = Din[COUNT_W-1:0];
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ctrl_q     <= '0;
      preset_q   <= '0;
      count_q    <= '0;
      irq_flag_q <= 1'b0;
      state_q    <= ST_IDLE;
    end else begin
      ctrl_q     <= ctrl_d;
      preset_q   <= preset_d;
      count_q    <= count_d;
      irq_flag_q <= irq_flag_d;
      state_q    <= state_d;
    end
  end

  always_comb begin
    case (Addr)
      ADDR_CTRL:   Dout = {28'd0, ctrl_q};
      ADDR_PRESET: Dout = 32'(preset_q);
      ADDR_COUNT:  Dout = 32'(count_q);
      default:     Dout = 32'(prescale_val);
    endcase
  end

  assign IRQ = ctrl_q.im & irq_flag_q;

endmodule

// File: tb/tb_timer_counter.sv
// Directed bench for timer_counter (default build, TC_PRESCALER_EN undefined).
module tb_timer_counter;

  logic        clk = 1'b0;
  logic        reset;
  logic [3:2]  Addr;
  logic        WE;
  logic [31:0] Din;
  logic [31:0] Dout;
  logic        IRQ;

  int n_chk  = 0;
  int n_pass = 0;

  timer_counter dut (
    .clk   (clk),
    .reset (reset),
    .Addr  (Addr),
    .WE    (WE),
    .Din   (Din),
    .Dout  (Dout),
    .IRQ   (IRQ)
  );

  always #5 clk = ~clk;

  task automatic cyc(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic wr(input logic [1:0] a, input logic [31:0] d);
    Addr = a;
    Din  = d;
    WE   = 1'b1;
    cyc(1);
    WE   = 1'b0;
  endtask

  task automatic rd(input logic [1:0] a, output logic [31:0] d);
    Addr = a;
    #1;
    d = Dout;
  endtask

  task automatic test_reset;
    logic [31:0] v;
    reset = 1'b1;
    cyc(2);
    reset = 1'b0;
    for (int a = 0; a < 4; a++) begin
      rd(a[1:0], v);
      n_chk++;
      if (v !== 32'd0) $display("FAIL reset_reg%0d: got %h want 0", a, v);
      else n_pass++;
    end
    n_chk++;
    if (IRQ !== 1'b0) $display("FAIL reset_irq: got %b want 0", IRQ);
    else n_pass++;
  endtask

  task automatic test_oneshot;
    logic [31:0] v;
    wr(1, 32'd5);
    wr(0, 32'h9);
    cyc(6);
    n_chk++;
    if (IRQ !== 1'b0) $display("FAIL oneshot_early: got %b want 0", IRQ);
    else n_pass++;
    cyc(1);
    n_chk++;
    if (IRQ !== 1'b1) $display("FAIL oneshot_rise: got %b want 1", IRQ);
    else n_pass++;
    cyc(3);
    n_chk++;
    if (IRQ !== 1'b1) $display("FAIL oneshot_hold: got %b want 1", IRQ);
    else n_pass++;
    rd(0, v);
    n_chk++;
    if (v !== 32'h8) $display("FAIL oneshot_ctrl_en_clr: got %h want 8", v);
    else n_pass++;
    wr(0, 32'h0);
    n_chk++;
    if (IRQ !== 1'b0) $display("FAIL oneshot_clear: got %b want 0", IRQ);
    else n_pass++;
    rd(2, v);
    n_chk++;
    if (v !== 32'd0) $display("FAIL oneshot_count: got %h want 0", v);
    else n_pass++;
  endtask

  task automatic test_reload;
    int pulses = 0;
    int bad = 0;
    logic exp;
    wr(1, 32'd3);
    wr(0, 32'hB);
    for (int k = 1; k <= 21; k++) begin
      cyc(1);
      exp = (k >= 5) && ((k - 5) % 5 == 0);
      if (IRQ === 1'b1) pulses++;
      if (IRQ !== exp && bad == 0) begin
        bad = 1;
        $display("FAIL reload_wave cycle %0d: got %b want %b", k, IRQ, exp);
      end
    end
    n_chk++;
    if (bad == 0) n_pass++;
    n_chk++;
    if (pulses != 4) $display("FAIL reload_pulses: got %0d want 4", pulses);
    else n_pass++;
    wr(0, 32'h0);
  endtask

  task automatic test_reset_midcount;
    logic [31:0] v;
    int seen = 0;
    wr(1, 32'd3);
    wr(0, 32'h9);
    cyc(3);
    rd(2, v);
    n_chk++;
    if (v !== 32'd2) $display("FAIL mid_count_before: got %h want 2", v);
    else n_pass++;
    reset = 1'b1;
    cyc(1);
    reset = 1'b0;
    for (int a = 0; a < 3; a++) begin
      rd(a[1:0], v);
      n_chk++;
      if (v !== 32'd0) $display("FAIL mid_reset_reg%0d: got %h want 0", a, v);
      else n_pass++;
    end
    for (int k = 0; k < 10; k++) begin
      if (IRQ !== 1'b0) seen++;
      cyc(1);
    end
    n_chk++;
    if (seen != 0) $display("FAIL mid_reset_no_irq: got %0d high cycles want 0", seen);
    else n_pass++;
  endtask

  task automatic test_preset_zero;
    logic [31:0] v;
    int seen = 0;
    wr(1, 32'd0);
    wr(0, 32'h9);
    cyc(2);
    n_chk++;
    if (IRQ !== 1'b0) $display("FAIL pz_early: got %b want 0", IRQ);
    else n_pass++;
    cyc(1);
    n_chk++;
    if (IRQ !== 1'b1) $display("FAIL pz_rise: got %b want 1", IRQ);
    else n_pass++;
    wr(0, 32'h0);
    wr(1, 32'd4);
    wr(0, 32'h1);
    for (int k = 1; k <= 10; k++) begin
      cyc(1);
      if (IRQ !== 1'b0) seen++;
      if (k == 4) begin
        rd(2, v);
        n_chk++;
        if (v !== 32'd2) $display("FAIL nomask_count_mid: got %h want 2", v);
        else n_pass++;
      end
    end
    n_chk++;
    if (seen != 0) $display("FAIL nomask_irq: got %0d high cycles want 0", seen);
    else n_pass++;
    rd(2, v);
    n_chk++;
    if (v !== 32'd0) $display("FAIL nomask_count_end: got %h want 0", v);
    else n_pass++;
    rd(0, v);
    n_chk++;
    if (v !== 32'd0) $display("FAIL nomask_ctrl: got %h want 0", v);
    else n_pass++;
  endtask

  task automatic test_en_stop;
    logic [31:0] v;
    wr(1, 32'd10);
    wr(0, 32'h1);
    cyc(4);
    wr(0, 32'h0);
    cyc(5);
    rd(2, v);
    n_chk++;
    if (v !== 32'd7) $display("FAIL en_stop_frozen: got %h want 7", v);
    else n_pass++;
  endtask

  task automatic test_preset_midcount;
    logic [31:0] v;
    wr(1, 32'd10);
    wr(0, 32'hB);
    cyc(3);
    wr(1, 32'd2);
    rd(2, v);
    n_chk++;
    if (v !== 32'd8) $display("FAIL preset_mid_count: got %h want 8", v);
    else n_pass++;
    cyc(8);
    n_chk++;
    if (IRQ !== 1'b1) $display("FAIL preset_mid_irq: got %b want 1", IRQ);
    else n_pass++;
    cyc(2);
    rd(2, v);
    n_chk++;
    if (v !== 32'd2) $display("FAIL preset_mid_reload: got %h want 2", v);
    else n_pass++;
    wr(0, 32'h0);
  endtask

  task automatic test_write_map;
    logic [31:0] v;
    wr(1, 32'd6);
    wr(0, 32'h1);
    cyc(2);
    wr(0, 32'h0);
    rd(2, v);
    n_chk++;
    if (v !== 32'd5) $display("FAIL map_count_pre: got %h want 5", v);
    else n_pass++;
    wr(2, 32'h55);
    rd(2, v);
    n_chk++;
    if (v !== 32'd5) $display("FAIL map_count_ro: got %h want 5", v);
    else n_pass++;
`ifndef TC_PRESCALER_EN
    wr(3, 32'hAB);
    rd(3, v);
    n_chk++;
    if (v !== 32'd0) $display("FAIL map_addr3: got %h want 0", v);
    else n_pass++;
`endif
    wr(0, 32'hFFFF_FFF8);
    rd(0, v);
    n_chk++;
    if (v !== 32'h8) $display("FAIL map_ctrl_upper: got %h want 8", v);
    else n_pass++;
    rd(1, v);
    n_chk++;
    if (v !== 32'd6) $display("FAIL map_preset: got %h want 6", v);
    else n_pass++;
    wr(0, 32'h0);
  endtask

  task automatic test_cpu_wins;
    logic [31:0] v;
    wr(1, 32'd0);
    wr(0, 32'h9);
    cyc(3);
    wr(0, 32'h9);
    rd(0, v);
    n_chk++;
    if (v !== 32'h9) $display("FAIL cpu_wins_ctrl: got %h want 9", v);
    else n_pass++;
    n_chk++;
    if (IRQ !== 1'b0) $display("FAIL cpu_wins_flag: got %b want 0", IRQ);
    else n_pass++;
    cyc(3);
    n_chk++;
    if (IRQ !== 1'b1) $display("FAIL cpu_wins_rerun: got %b want 1", IRQ);
    else n_pass++;
    wr(0, 32'h0);
  endtask

  initial begin
    reset = 1'b1;
    Addr  = 2'd0;
    WE    = 1'b0;
    Din   = 32'd0;
    test_reset();
    test_oneshot();
    test_reload();
    test_reset_midcount();
    test_preset_zero();
    test_en_stop();
    test_preset_midcount();
    test_write_map();
    test_cpu_wins();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
